// File: rtl/v850_pkg.sv
// Shared types and helpers for the V850 instruction fetch unit.
// Optional performance counters in the top are enabled with V850_FETCH_PERF_EN.
package v850_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          QDEPTH_HW_DEFAULT = 8;

  // Formats V-VII carry 11 in bits [10:9] of their first halfword.
  function automatic logic is_len32(input logic [15:0] hw);
    return (hw[10:9] == 2'b11);
  endfunction

endpackage

// File: rtl/v850_hw_queue.sv
// Circular halfword prefetch FIFO: push 0/1/2, pop 0/1/2 per cycle, flush wins over both.
// Callers guarantee push never exceeds post-pop space and pop never exceeds count.
module v850_hw_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic [1:0]    i_push_cnt,
  input  logic [15:0]   i_push_hw0,
  input  logic [15:0]   i_push_hw1,
  input  logic [1:0]    i_pop_cnt,
  output logic [15:0]   o_head0,
  output logic [15:0]   o_head1,
  output logic [CW-1:0] o_count
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_ptr1;
  logic [AW-1:0] w_rd_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign w_rd_ptr1 = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_cnt != 2'd0) r_mem[r_wr_ptr]  <= i_push_hw0;
      if (i_push_cnt == 2'd2) r_mem[w_wr_ptr1] <= i_push_hw1;
      r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
      r_count  <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
    end
  end

  assign o_head0 = r_mem[r_rd_ptr];
  assign o_head1 = r_mem[w_rd_ptr1];
  assign o_count = r_count;

endmodule

// File: rtl/v850_fetch_unit.sv
// V850 fetch stage: word fetch into a halfword queue, 16/32-bit split, valid/ready output.
// Define V850_FETCH_PERF_EN to add saturating stall/flush counters.
module v850_fetch_unit
  import v850_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          QDEPTH_HW = QDEPTH_HW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        inst_len32,
  output logic [31:0] inst_pc,
`ifdef V850_FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid (imem_req /
  // inst_valid) and the matching ready (imem_ack / inst_ready) are both high;
  // the offering side holds its address/data stable until that edge.

  localparam int CW = $clog2(QDEPTH_HW) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_head_pc;
  logic          r_skip_lo;

  logic [15:0]   w_head0;
  logic [15:0]   w_head1;
  logic [CW-1:0] w_count;
  logic          w_head_len32;
  logic          w_valid;
  logic          w_pop;
  logic [1:0]    w_pop_cnt;
  logic [CW-1:0] w_space;
  logic          w_issue;
  logic          w_take;
  logic [31:0]   w_issue_addr;
  logic [31:0]   w_redir_word;
  logic [1:0]    w_push_cnt;
  logic [15:0]   w_push_hw0;

  v850_hw_queue #(.DEPTH(QDEPTH_HW)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (redirect_valid),
    .i_push_cnt (w_push_cnt),
    .i_push_hw0 (w_push_hw0),
    .i_push_hw1 (imem_rdata[31:16]),
    .i_pop_cnt  (w_pop_cnt),
    .o_head0    (w_head0),
    .o_head1    (w_head1),
    .o_count    (w_count)
  );

  assign w_head_len32 = is_len32(w_head0);
  assign w_valid      = (w_count >= CW'(1) && !w_head_len32) ||
                        (w_count >= CW'(2) &&  w_head_len32);
  assign w_pop        = w_valid && inst_ready;
  assign w_pop_cnt    = w_pop ? (w_head_len32 ? 2'd2 : 2'd1) : 2'd0;
  assign w_space      = CW'(QDEPTH_HW) - w_count + CW'(w_pop_cnt);
  assign w_redir_word = {redirect_pc[31:2], 2'b00};
  assign w_issue_addr = redirect_valid ? w_redir_word : r_fetch_addr;
  assign w_push_cnt   = w_take ? (r_skip_lo ? 2'd1 : 2'd2) : 2'd0;
  assign w_push_hw0   = r_skip_lo ? imem_rdata[31:16] : imem_rdata[15:0];

  // A redirect seen in IDLE issues straight to the new target: the queue is
  // being flushed, so space is guaranteed and the restart saves a cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect_valid || (w_space >= CW'(2))) begin
          w_state_nxt = WAIT;
          w_issue     = 1'b1;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          w_take      = !redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_req_addr   <= {RESET_PC[31:2], 2'b00};
      r_head_pc    <= RESET_PC & ~32'h1;
      r_skip_lo    <= RESET_PC[1];
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_req_addr <= w_issue_addr;
      if (redirect_valid) begin
        r_fetch_addr <= w_redir_word;
        r_head_pc    <= redirect_pc & ~32'h1;
        r_skip_lo    <= redirect_pc[1];
      end else begin
        if (w_take) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
          r_skip_lo    <= 1'b0;
        end
        if (w_pop) r_head_pc <= r_head_pc + (w_head_len32 ? 32'd4 : 32'd2);
      end
    end
  end

  // r_req_addr stays frozen through DROP so the abandoned read completes cleanly.
  assign imem_req    = (r_state != IDLE);
  assign imem_addr   = r_req_addr;
  assign inst_valid  = w_valid;
  assign inst_len32  = w_head_len32 && (w_count != '0);
  assign inst_data   = {(w_head_len32 && w_count >= CW'(2)) ? w_head1 : 16'h0000,
                        (w_count != '0) ? w_head0 : 16'h0000};
  assign inst_pc     = r_head_pc;
  assign o_dbg_state = r_state;

`ifdef V850_FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (inst_ready && !w_valid && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redirect_valid && r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
